// File: rtl/ps2_mouse_tracker.sv
// ps2_mouse_tracker
//   Receive-only PS/2 mouse decoder. Deserialises 11-bit PS/2 frames, assembles
//   standard 3-byte stream packets, and keeps an absolute cursor position clamped
//   to [0, X_MAX] x [0, Y_MAX]. All outputs are registered.
//
// Ports
//   clk        in   system clock
//   rst_n      in   synchronous reset, active-low
//   ps2_clk    in   PS/2 clock from the mouse (asynchronous)
//   ps2_data   in   PS/2 data from the mouse (asynchronous)
//   xpos       out  absolute x, 0..X_MAX, increasing to the right
//   ypos       out  absolute y, 0..Y_MAX, increasing downward
//   left       out  left button state from the last packet
//   right      out  right button state from the last packet
//   middle     out  middle button state from the last packet
//   new_event  out  1-cycle pulse when a packet is committed
//   frame_err  out  1-cycle pulse when a byte or frame is discarded
//
// Configuration
//   PS2_TIMEOUT_EN  when defined, an idle counter resynchronises framing after
//                   TIMEOUT_CYC clk cycles without a PS/2 clock falling edge.
module ps2_mouse_tracker #(
  parameter int unsigned X_MAX       = 959,
  parameter int unsigned Y_MAX       = 639,
  parameter int unsigned X_INIT      = 479,
  parameter int unsigned Y_INIT      = 319,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        left,
  output logic        right,
  output logic        middle,
  output logic        new_event,
  output logic        frame_err
);

  typedef enum logic [1:0] {StB0, StB1, StB2} byte_st_e;

  localparam logic signed [13:0] XMaxS = 14'(X_MAX);
  localparam logic signed [13:0] YMaxS = 14'(Y_MAX);

  // Synchronisers plus one extra stage of the synchronised clock for edge detect
  logic        clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_prev_q, clk_prev_d;
  logic        dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;

  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  byte_st_e    byte_st_q, byte_st_d;
  logic [7:0]  status_q, status_d;
  logic [7:0]  dx_q, dx_d;

  logic [11:0] xpos_q, xpos_d, ypos_q, ypos_d;
  logic        left_q, left_d, right_q, right_d, middle_q, middle_d;
  logic        new_event_q, new_event_d, frame_err_q, frame_err_d;

`ifdef PS2_TIMEOUT_EN
  localparam int unsigned IdleW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IdleW-1:0] IdleMax = IdleW'(TIMEOUT_CYC);
  logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
`endif

  logic              fall;
  logic              byte_done;
  logic signed [13:0] x_sum, y_sum;
  logic [11:0]       x_clamp, y_clamp;

  always_comb begin
    clk_s1_d    = ps2_clk;
    clk_s2_d    = clk_s1_q;
    clk_prev_d  = clk_s2_q;
    dat_s1_d    = ps2_data;
    dat_s2_d    = dat_s1_q;

    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    byte_st_d   = byte_st_q;
    status_d    = status_q;
    dx_d        = dx_q;
    xpos_d      = xpos_q;
    ypos_d      = ypos_q;
    left_d      = left_q;
    right_d     = right_q;
    middle_d    = middle_q;
    new_event_d = 1'b0;
    frame_err_d = 1'b0;
    byte_done   = 1'b0;

    fall = clk_prev_q & ~clk_s2_q;

    // Movement: dx from the stored byte 1, dy is the byte just received (byte 2)
    x_sum = $signed({2'b00, xpos_q}) + $signed({{5{status_q[4]}}, status_q[4], dx_q});
    y_sum = $signed({2'b00, ypos_q}) - $signed({{5{status_q[5]}}, status_q[5], shift_q});

    if (x_sum[13])          x_clamp = 12'd0;
    else if (x_sum > XMaxS) x_clamp = 12'(X_MAX);
    else                    x_clamp = x_sum[11:0];

    if (y_sum[13])          y_clamp = 12'd0;
    else if (y_sum > YMaxS) y_clamp = 12'(Y_MAX);
    else                    y_clamp = y_sum[11:0];

    // Bit level
    if (fall) begin
      if (bit_cnt_q == 4'd0) begin
        // Only a 0 start bit opens a frame
        if (!dat_s2_q) bit_cnt_d = 4'd1;
      end else if (bit_cnt_q <= 4'd8) begin
        shift_d   = {dat_s2_q, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end else if (bit_cnt_q == 4'd9) begin
        par_d     = dat_s2_q;
        bit_cnt_d = 4'd10;
      end else begin
        bit_cnt_d = 4'd0;
        // Odd parity: data plus parity bit must hold an odd number of ones
        if (!dat_s2_q || !(^{shift_q, par_q})) begin
          frame_err_d = 1'b1;
          byte_st_d   = StB0;
        end else begin
          byte_done = 1'b1;
        end
      end
    end

    // Byte level
    if (byte_done) begin
      unique case (byte_st_q)
        StB0: begin
          // Bit 3 is always set in a status byte; anything else means lost framing
          if (shift_q[3]) begin
            status_d  = shift_q;
            byte_st_d = StB1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        StB1: begin
          dx_d      = shift_q;
          byte_st_d = StB2;
        end
        StB2: begin
          byte_st_d   = StB0;
          new_event_d = 1'b1;
          left_d      = status_q[0];
          right_d     = status_q[1];
          middle_d    = status_q[2];
          if (!status_q[6]) xpos_d = x_clamp;
          if (!status_q[7]) ypos_d = y_clamp;
        end
        default: byte_st_d = StB0;
      endcase
    end

`ifdef PS2_TIMEOUT_EN
    idle_cnt_d = idle_cnt_q;
    if (fall) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != IdleMax) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
      // Fires once on the cycle the counter reaches the limit, then saturates
      if (idle_cnt_d == IdleMax && (bit_cnt_q != 4'd0 || byte_st_q != StB0)) begin
        bit_cnt_d   = 4'd0;
        byte_st_d   = StB0;
        frame_err_d = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      clk_prev_q  <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'd0;
      par_q       <= 1'b0;
      byte_st_q   <= StB0;
      status_q    <= 8'd0;
      dx_q        <= 8'd0;
      xpos_q      <= 12'(X_INIT);
      ypos_q      <= 12'(Y_INIT);
      left_q      <= 1'b0;
      right_q     <= 1'b0;
      middle_q    <= 1'b0;
      new_event_q <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef PS2_TIMEOUT_EN
      idle_cnt_q  <= '0;
`endif
    end else begin
      clk_s1_q    <= clk_s1_d;
      clk_s2_q    <= clk_s2_d;
      clk_prev_q  <= clk_prev_d;
      dat_s1_q    <= dat_s1_d;
      dat_s2_q    <= dat_s2_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      byte_st_q   <= byte_st_d;
      status_q    <= status_d;
      dx_q        <= dx_d;
      xpos_q      <= xpos_d;
      ypos_q      <= ypos_d;
      left_q      <= left_d;
      right_q     <= right_d;
      middle_q    <= middle_d;
      new_event_q <= new_event_d;
      frame_err_q <= frame_err_d;
`ifdef PS2_TIMEOUT_EN
      idle_cnt_q  <= idle_cnt_d;
`endif
    end
  end

  assign xpos      = xpos_q;
  assign ypos      = ypos_q;
  assign left      = left_q;
  assign right     = right_q;
  assign middle    = middle_q;
  assign new_event = new_event_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Scoreboard bench for ps2_mouse_tracker: the stimulus process pushes the
// expected pulse (packet commit with position/buttons, or frame error) before
// driving PS/2 bytes; the monitor pops and compares whenever a pulse appears.
module tb_ps2_mouse_tracker;

  localparam int unsigned TimeoutCyc = 300;

  logic        clk;
  logic        rst_n;
  logic        ps2_clk;
  logic        ps2_data;
  logic [11:0] xpos, ypos;
  logic        left, right, middle, new_event, frame_err;

  ps2_mouse_tracker #(
    .X_MAX      (959),
    .Y_MAX      (639),
    .X_INIT     (479),
    .Y_INIT     (319),
    .TIMEOUT_CYC(TimeoutCyc)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .xpos     (xpos),
    .ypos     (ypos),
    .left     (left),
    .right    (right),
    .middle   (middle),
    .new_event(new_event),
    .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [11:0] x;
    logic [11:0] y;
    logic        l;
    logic        r;
    logic        m;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  bit   chk_rst = 1'b0;
  bit   done = 1'b0;
  bit   final_checked = 1'b0;

  // Monitor: the only process that steps the counters
  always @(negedge clk) begin
    if (chk_rst) begin
      tests++;
      if (xpos !== 12'd479 || ypos !== 12'd319 || left !== 1'b0 || right !== 1'b0 ||
          middle !== 1'b0 || new_event !== 1'b0 || frame_err !== 1'b0) begin
        fails++;
        $display("FAIL reset_state got x=%0d y=%0d lrm=%b%b%b ev=%b err=%b, required x=479 y=319 lrm=000 ev=0 err=0",
                 xpos, ypos, left, right, middle, new_event, frame_err);
      end
    end else if (rst_n) begin
      if (new_event === 1'b1 && frame_err === 1'b1) begin
        tests++;
        fails++;
        $display("FAIL both_pulses got ev=1 err=1, required at most one");
      end else if (new_event === 1'b1 || frame_err === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_pulse got ev=%b err=%b x=%0d y=%0d, required no pulse",
                   new_event, frame_err, xpos, ypos);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.is_err) begin
            if (frame_err !== 1'b1) begin
              fails++;
              $display("FAIL pulse_kind got ev=%b err=%b, required frame_err", new_event, frame_err);
            end
          end else if (new_event !== 1'b1 || xpos !== mon_e.x || ypos !== mon_e.y ||
                       left !== mon_e.l || right !== mon_e.r || middle !== mon_e.m) begin
            fails++;
            $display("FAIL commit got ev=%b x=%0d y=%0d lrm=%b%b%b, required ev=1 x=%0d y=%0d lrm=%b%b%b",
                     new_event, xpos, ypos, left, right, middle,
                     mon_e.x, mon_e.y, mon_e.l, mon_e.r, mon_e.m);
          end
        end
      end
    end
    if (done && !final_checked) begin
      final_checked = 1'b1;
      tests++;
      if (exp_q.size() != 0) begin
        fails++;
        $display("FAIL missing_pulses got %0d outstanding, required 0", exp_q.size());
      end
    end
  end

  task automatic send_bit(input logic v);
    @(negedge clk);
    ps2_data = v;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (8) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(bad_par ? ^b : ~^b);
    send_bit(1'b1);
    ps2_data = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1;
    e.x = '0; e.y = '0; e.l = 1'b0; e.r = 1'b0; e.m = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                     input int ex, input int ey);
    exp_t e;
    e.is_err = 1'b0;
    e.x = 12'(ex);
    e.y = 12'(ey);
    e.l = b0[0];
    e.r = b0[1];
    e.m = b0[2];
    exp_q.push_back(e);
    send_byte(b0, 1'b0);
    send_byte(b1, 1'b0);
    send_byte(b2, 1'b0);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(posedge clk);
    chk_rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_rst = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    do_reset();

    // Partial frame followed by reset must leave no stale bit count
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    do_reset();

    // Basic packet
    pkt(8'h09, 8'h0A, 8'h00, 489, 319);
    // Walk to 955, clamp at X_MAX, then negative dx
    pkt(8'h08, 8'hFF, 8'h00, 744, 319);
    pkt(8'h08, 8'hD3, 8'h00, 955, 319);
    pkt(8'h08, 8'h0A, 8'h00, 959, 319);
    pkt(8'h18, 8'hF6, 8'h00, 949, 319);
    // Positive dy moves up, negative dy moves down
    pkt(8'h08, 8'h00, 8'h05, 949, 314);
    pkt(8'h28, 8'h00, 8'hFB, 949, 319);
    // Bad parity discards the byte
    push_err();
    send_byte(8'h0A, 1'b1);
    pkt(8'h0A, 8'h01, 8'h00, 950, 319);
    // Status byte with D3=0 is rejected
    push_err();
    send_byte(8'h00, 1'b0);
    pkt(8'h09, 8'h01, 8'h00, 951, 319);
    // dy=-256 twice: clamp at Y_MAX
    pkt(8'h28, 8'h00, 8'h00, 951, 575);
    pkt(8'h28, 8'h00, 8'h00, 951, 639);
    // dx=-256 repeatedly: clamp at 0
    pkt(8'h18, 8'h00, 8'h00, 695, 639);
    pkt(8'h18, 8'h00, 8'h00, 439, 639);
    pkt(8'h18, 8'h00, 8'h00, 183, 639);
    pkt(8'h18, 8'h00, 8'h00, 0, 639);
`ifdef PS2_TIMEOUT_EN
    push_err();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    repeat (TimeoutCyc + 50) @(negedge clk);
    pkt(8'h09, 8'h05, 8'h00, 5, 639);
`else
    // X overflow keeps xpos
    pkt(8'h48, 8'hFF, 8'h00, 0, 639);
`endif

    repeat (50) @(negedge clk);
    done = 1'b1;
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
